// File: rtl/demultiplexer_stream_2_32.sv
// One-to-four stream demultiplexer.
// Each channel is a single-entry buffer with a valid/ready handshake.
module demultiplexer_stream_2_32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_select,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [WIDTH-1:0] out_1,
   output logic [WIDTH-1:0] out_2,
   output logic [WIDTH-1:0] out_3,
   output logic [WIDTH-1:0] out_4,
   output logic             busy
);

   logic [3:0]       full;
   logic [3:0]       load;
   logic [WIDTH-1:0] data [4];

   // A full channel can still accept when its word leaves on the same edge.
   assign in_ready = !full[in_select] || out_ready[in_select];

   always_comb begin
      load = 4'b0000;
      if (in_valid && in_ready)
         load[in_select] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         full <= 4'b0000;
         for (int i = 0; i < 4; i++)
            data[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (load[i])
               data[i] <= in_data;
            full[i] <= load[i] || (full[i] && !out_ready[i]);
         end
      end
   end

   assign out_valid = full;
   assign busy      = |full;
   assign out_1     = data[0];
   assign out_2     = data[1];
   assign out_3     = data[2];
   assign out_4     = data[3];

endmodule

// File: tb/tb_demultiplexer_stream_2_32.sv
// Directed and random-traffic checks for demultiplexer_stream_2_32.
module tb_demultiplexer_stream_2_32;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in_data;
   logic [1:0]  in_select;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_1, out_2, out_3, out_4;
   logic        busy;

   int checks = 0;
   int errs   = 0;

   demultiplexer_stream_2_32 #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_select (in_select),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_1     (out_1),
      .out_2     (out_2),
      .out_3     (out_3),
      .out_4     (out_4),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] get_out(int i);
      case (i)
         0: return out_1;
         1: return out_2;
         2: return out_3;
         default: return out_4;
      endcase
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 4'b0000;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b1;
      in_select = 2'b01;
      in_data = 32'h1234_5678;
      out_ready = 4'b0000;
      step();
      reset = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 4'b0000 || busy !== 1'b0) begin
         errs++;
         $display("FAIL reset_flags: out_valid=%b busy=%b want 0000/0", out_valid, busy);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (get_out(i) !== 32'h0) begin
            errs++;
            $display("FAIL reset_data ch%0d: got %h want 0", i + 1, get_out(i));
         end
         in_select = 2'(i);
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_ready sel%0d: got %b want 1", i, in_ready);
         end
      end
   endtask

   task automatic test_single_word();
      do_reset();
      in_select = 2'b10;
      in_data = 32'hDEADBEEF;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 4'b0100 || out_3 !== 32'hDEADBEEF || busy !== 1'b1) begin
         errs++;
         $display("FAIL single_word: valid=%b out_3=%h busy=%b want 0100/deadbeef/1",
                  out_valid, out_3, busy);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      in_select = 2'b00;
      in_data = 32'hAAAA_0001;
      in_valid = 1'b1;
      step();
      in_data = 32'hBBBB_0002;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errs++;
         $display("FAIL bp_blocked: in_ready=%b want 0", in_ready);
      end
      step();
      checks++;
      if (out_1 !== 32'hAAAA_0001 || out_valid !== 4'b0001) begin
         errs++;
         $display("FAIL bp_hold: out_1=%h valid=%b want aaaa0001/0001", out_1, out_valid);
      end
      in_select = 2'b01;
      in_data = 32'hCCCC_0003;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errs++;
         $display("FAIL bp_other: in_ready=%b want 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_2 !== 32'hCCCC_0003 || out_valid !== 4'b0011) begin
         errs++;
         $display("FAIL bp_land: out_2=%h valid=%b want cccc0003/0011", out_2, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 4'b1111;
      in_select = 2'b11;
      for (int k = 1; k <= 4; k++) begin
         in_data = 32'(k);
         in_valid = 1'b1;
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL stream_ready k=%0d: got %b want 1", k, in_ready);
         end
         step();
         checks++;
         if (out_4 !== 32'(k) || out_valid[3] !== 1'b1) begin
            errs++;
            $display("FAIL stream_out k=%0d: out_4=%h valid=%b want %h/1",
                     k, out_4, out_valid[3], k);
         end
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 4'b0000 || out_4 !== 32'd4) begin
         errs++;
         $display("FAIL stream_drain: valid=%b out_4=%h want 0000/4", out_valid, out_4);
      end
   endtask

   task automatic test_stall_hold();
      do_reset();
      in_select = 2'b01;
      in_data = 32'h5A5A5A5A;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      in_data = 32'hFFFF_FFFF;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (out_2 !== 32'h5A5A5A5A || out_valid[1] !== 1'b1) begin
            errs++;
            $display("FAIL stall c=%0d: out_2=%h valid=%b want 5a5a5a5a/1",
                     c, out_2, out_valid[1]);
         end
         step();
      end
      out_ready = 4'b0010;
      step();
      out_ready = 4'b0000;
      checks++;
      if (out_valid[1] !== 1'b0 || out_2 !== 32'h5A5A5A5A || busy !== 1'b0) begin
         errs++;
         $display("FAIL stall_release: valid=%b out_2=%h busy=%b want 0/5a5a5a5a/0",
                  out_valid[1], out_2, busy);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_select = 2'(i);
         in_data = 32'h100 + 32'(i);
         step();
      end
      checks++;
      if (out_valid !== 4'b1111) begin
         errs++;
         $display("FAIL mid_fill: valid=%b want 1111", out_valid);
      end
      reset = 1'b1;
      in_select = 2'b00;
      in_data = 32'h9999_9999;
      step();
      reset = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 4'b0000 || busy !== 1'b0 || in_ready !== 1'b1 ||
          out_1 !== 0 || out_2 !== 0 || out_3 !== 0 || out_4 !== 0) begin
         errs++;
         $display("FAIL mid_reset: valid=%b busy=%b rdy=%b outs=%h %h %h %h want all 0, rdy 1",
                  out_valid, busy, in_ready, out_1, out_2, out_3, out_4);
      end
   endtask

   task automatic test_random();
      logic [31:0] q [4][$];
      logic [31:0] prev [4];
      logic [3:0]  hold;
      logic [3:0]  mfull;
      logic        exp_rdy;
      logic [31:0] seq;
      do_reset();
      seq = 32'h0;
      hold = 4'b0000;
      for (int c = 0; c < 10000; c++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_select = 2'($urandom_range(0, 3));
         in_data = in_valid ? seq : 32'($urandom);
         out_ready = 4'($urandom_range(0, 15));
         #1;
         for (int i = 0; i < 4; i++)
            mfull[i] = (q[i].size() != 0);
         exp_rdy = !mfull[in_select] || out_ready[in_select];
         checks++;
         if (out_valid !== mfull || in_ready !== exp_rdy) begin
            errs++;
            $display("FAIL rnd_state c=%0d: valid=%b rdy=%b want %b/%b",
                     c, out_valid, in_ready, mfull, exp_rdy);
         end
         for (int i = 0; i < 4; i++) begin
            if (hold[i]) begin
               checks++;
               if (get_out(i) !== prev[i]) begin
                  errs++;
                  $display("FAIL rnd_hold c=%0d ch%0d: got %h want %h",
                           c, i + 1, get_out(i), prev[i]);
               end
            end
            if (mfull[i] && out_ready[i]) begin
               checks++;
               if (get_out(i) !== q[i][0]) begin
                  errs++;
                  $display("FAIL rnd_order c=%0d ch%0d: got %h want %h",
                           c, i + 1, get_out(i), q[i][0]);
               end
               void'(q[i].pop_front());
            end
            hold[i] = mfull[i] && !out_ready[i];
            prev[i] = get_out(i);
         end
         if (in_valid && exp_rdy) begin
            q[in_select].push_back(in_data);
            seq++;
         end
         step();
      end
      in_valid = 1'b0;
      out_ready = 4'b0000;
      #1;
      for (int i = 0; i < 4; i++)
         mfull[i] = (q[i].size() != 0);
      checks++;
      if (out_valid !== mfull) begin
         errs++;
         $display("FAIL rnd_final: valid=%b want %b", out_valid, mfull);
      end
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in_select = 2'b00;
      in_data = '0;
      out_ready = 4'b0000;
      test_reset();
      test_single_word();
      test_backpressure();
      test_back_to_back();
      test_stall_hold();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end

endmodule
